// File: rtl/bank_cmd_sequencer.sv
// Turns one DRAM request at a time into PRE/ACT/RD/WR bus commands.
// Keeps an open-row table per bank and holds off commands through the activate and precharge windows.
module bank_cmd_sequencer #(
  parameter int BANK_GROUPS        = 8,
  parameter int BANKS_PER_GROUP    = 8,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int DATA_WIDTH         = 64,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic [$clog2(BANK_GROUPS)-1:0]     bank_group_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] bank_in,
  input  logic [ROW_BITS-1:0]                row_in,
  input  logic [COL_BITS-1:0]                col_in,
  input  logic                               write_in,
  input  logic [DATA_WIDTH-1:0]              val_in,
  input  logic                               cmd_ready_in,
  output logic                               cmd_valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic [DATA_WIDTH-1:0]              val_out
);

  localparam int BGW     = $clog2(BANK_GROUPS);
  localparam int BKW     = $clog2(BANKS_PER_GROUP);
  localparam int BANKS   = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int BW      = $clog2(BANKS);
  localparam int MAX_LAT = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int TW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_RD  = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;

  generate
    if (ACTIVATION_LATENCY < 1) begin : g_bad_act_lat
      $error("ACTIVATION_LATENCY must be at least 1");
    end
    if (PRECHARGE_LATENCY < 1) begin : g_bad_pre_lat
      $error("PRECHARGE_LATENCY must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECIDE   = 3'd1,
    S_PRE      = 3'd2,
    S_WAIT_PRE = 3'd3,
    S_ACT      = 3'd4,
    S_WAIT_ACT = 3'd5,
    S_RW       = 3'd6
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            cmd;
    logic [BGW-1:0]        bg;
    logic [BKW-1:0]        bank;
    logic [ROW_BITS-1:0]   row;
    logic [COL_BITS-1:0]   col;
    logic [DATA_WIDTH-1:0] val;
  } cmd_t;

  state_t                state_q;
  cmd_t                  cmd_q;
  logic                  req_ready_q;
  logic [TW-1:0]         timer_q;
  logic [BGW-1:0]        bg_q;
  logic [BKW-1:0]        bank_q;
  logic [ROW_BITS-1:0]   row_q;
  logic [COL_BITS-1:0]   col_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] val_q;
  logic [BANKS-1:0]      open_valid_q;
  logic [ROW_BITS-1:0]   open_row_q [BANKS];
  logic [BW-1:0]         idx_s;

  assign idx_s = BW'(bg_q) * BW'(BANKS_PER_GROUP) + BW'(bank_q);

  function automatic cmd_t mk_cmd(input logic [2:0] c, input logic [BGW-1:0] bg,
                                  input logic [BKW-1:0] bk, input logic [ROW_BITS-1:0] r,
                                  input logic [COL_BITS-1:0] cl, input logic [DATA_WIDTH-1:0] v);
    cmd_t t;
    t.valid = 1'b1;
    t.cmd   = c;
    t.bg    = bg;
    t.bank  = bk;
    t.row   = r;
    t.col   = cl;
    t.val   = v;
    return t;
  endfunction

  // Column command for the captured request; data only travels with writes.
  function automatic cmd_t mk_rw(input logic wr, input logic [BGW-1:0] bg, input logic [BKW-1:0] bk,
                                 input logic [ROW_BITS-1:0] r, input logic [COL_BITS-1:0] cl,
                                 input logic [DATA_WIDTH-1:0] v);
    return mk_cmd(wr ? CMD_WR : CMD_RD, bg, bk, r, cl, wr ? v : {DATA_WIDTH{1'b0}});
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      req_ready_q  <= 1'b1;
      timer_q      <= '0;
      bg_q         <= '0;
      bank_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      write_q      <= 1'b0;
      val_q        <= '0;
      open_valid_q <= '0;
      for (int i = 0; i < BANKS; i++) open_row_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_in && req_ready_q) begin
            bg_q        <= bank_group_in;
            bank_q      <= bank_in;
            row_q       <= row_in;
            col_q       <= col_in;
            write_q     <= write_in;
            val_q       <= val_in;
            req_ready_q <= 1'b0;
            state_q     <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (open_valid_q[idx_s] && (open_row_q[idx_s] == row_q)) begin
            cmd_q   <= mk_rw(write_q, bg_q, bank_q, row_q, col_q, val_q);
            state_q <= S_RW;
          end else if (!open_valid_q[idx_s]) begin
            cmd_q   <= mk_cmd(CMD_ACT, bg_q, bank_q, row_q, '0, '0);
            state_q <= S_ACT;
          end else begin
            cmd_q   <= mk_cmd(CMD_PRE, bg_q, bank_q, open_row_q[idx_s], '0, '0);
            state_q <= S_PRE;
          end
        end
        S_PRE: begin
          if (cmd_ready_in) begin
            open_valid_q[idx_s] <= 1'b0;
            timer_q             <= TW'(PRECHARGE_LATENCY);
            cmd_q               <= '0;
            state_q             <= S_WAIT_PRE;
          end
        end
        S_WAIT_PRE: begin
          timer_q <= timer_q - TW'(1);
          if (timer_q == TW'(1)) begin
            cmd_q   <= mk_cmd(CMD_ACT, bg_q, bank_q, row_q, '0, '0);
            state_q <= S_ACT;
          end
        end
        S_ACT: begin
          if (cmd_ready_in) begin
            open_valid_q[idx_s] <= 1'b1;
            open_row_q[idx_s]   <= row_q;
            timer_q             <= TW'(ACTIVATION_LATENCY);
            cmd_q               <= '0;
            state_q             <= S_WAIT_ACT;
          end
        end
        S_WAIT_ACT: begin
          timer_q <= timer_q - TW'(1);
          if (timer_q == TW'(1)) begin
            cmd_q   <= mk_rw(write_q, bg_q, bank_q, row_q, col_q, val_q);
            state_q <= S_RW;
          end
        end
        S_RW: begin
          if (cmd_ready_in) begin
            cmd_q       <= '0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          cmd_q       <= '0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_out  = req_ready_q;
  assign cmd_valid_out  = cmd_q.valid;
  assign cmd_out        = cmd_q.valid ? cmd_q.cmd : CMD_NOP;
  assign bank_group_out = cmd_q.bg;
  assign bank_out       = cmd_q.bank;
  assign row_out        = cmd_q.row;
  assign col_out        = cmd_q.col;
  assign val_out        = cmd_q.val;

endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Directed scoreboard bench for bank_cmd_sequencer: stimulus pushes expected commands with their
// handshake edge, a negedge monitor pops and compares every command-bus handshake.
module tb_bank_cmd_sequencer;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] ACT = 3'b001;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] RD  = 3'b011;
  localparam logic [2:0] WR  = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  bg_i = '0;
  logic [2:0]  bank_i = '0;
  logic [7:0]  row_i = '0;
  logic [3:0]  col_i = '0;
  logic        wr_i = 1'b0;
  logic [63:0] val_i = '0;
  logic        cmd_ready = 1'b1;
  logic        cmd_valid;
  logic [2:0]  cmd_o;
  logic [2:0]  bg_o;
  logic [2:0]  bank_o;
  logic [7:0]  row_o;
  logic [3:0]  col_o;
  logic [63:0] val_o;

  typedef struct {
    logic [2:0]  cmd;
    logic [2:0]  bg;
    logic [2:0]  bank;
    logic [7:0]  row;
    logic [3:0]  col;
    logic [63:0] val;
    int          at_edge;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_act_run = 0;

  bank_cmd_sequencer dut (
    .clk_in(clk), .rst_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .bank_group_in(bg_i), .bank_in(bank_i), .row_in(row_i), .col_in(col_i),
    .write_in(wr_i), .val_in(val_i),
    .cmd_ready_in(cmd_ready), .cmd_valid_out(cmd_valid), .cmd_out(cmd_o),
    .bank_group_out(bg_o), .bank_out(bank_o), .row_out(row_o), .col_out(col_o),
    .val_out(val_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic push(logic [2:0] c, logic [2:0] bg, logic [2:0] bk, logic [7:0] r,
                      logic [3:0] cl, logic [63:0] v, int e);
    exp_t x;
    x.cmd = c; x.bg = bg; x.bank = bk; x.row = r; x.col = cl; x.val = v; x.at_edge = e;
    exp_q.push_back(x);
  endtask

  // Returns the edge number on which the request was accepted (-1 on timeout).
  task automatic do_req(logic [2:0] bg, logic [2:0] bk, logic [7:0] r, logic [3:0] cl,
                        logic wr, logic [63:0] v, output int t);
    @(posedge clk); #1;
    bg_i = bg; bank_i = bk; row_i = r; col_i = cl; wr_i = wr; val_i = v;
    req_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        t = cyc + 1;
        break;
      end
    end
    if (t < 0) chk("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (2) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability and idle zeroing.
  initial begin
    logic prev_stall;
    int   run;
    exp_t held;
    exp_t e;
    prev_stall = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else if (cmd_valid) begin
        if (prev_stall) begin
          chk("stall_stable", {cmd_o, bg_o, bank_o, row_o, col_o},
              {held.cmd, held.bg, held.bank, held.row, held.col});
          chk("stall_stable_val", val_o, held.val);
          run++;
        end else begin
          run = 1;
        end
        held.cmd = cmd_o; held.bg = bg_o; held.bank = bank_o;
        held.row = row_o; held.col = col_o; held.val = val_o;
        if (cmd_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_cmd", 64'(cmd_o), 64'(NOP));
          end else begin
            e = exp_q.pop_front();
            chk("cmd", 64'(cmd_o), 64'(e.cmd));
            chk("bank_group", 64'(bg_o), 64'(e.bg));
            chk("bank", 64'(bank_o), 64'(e.bank));
            chk("row", 64'(row_o), 64'(e.row));
            chk("col", 64'(col_o), 64'(e.col));
            chk("val", val_o, e.val);
            chk("handshake_edge", 64'(cyc + 1), 64'(e.at_edge));
          end
          if (cmd_o == ACT) last_act_run = run;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
        end
      end else begin
        if (prev_stall) chk("cmd_dropped_while_stalled", 64'd0, 64'd1);
        chk("idle_fields_zero", {cmd_o, bg_o, bank_o, row_o, col_o, val_o}, 84'd0);
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int t;
    // Reset state
    #23;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("reset_cmd", 64'(cmd_o), 64'(NOP));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Closed bank read
    do_req(3'd3, 3'd2, 8'h55, 4'hA, 1'b0, 64'd0, t);
    push(ACT, 3'd3, 3'd2, 8'h55, 4'h0, 64'd0, t + 2);
    push(RD,  3'd3, 3'd2, 8'h55, 4'hA, 64'd0, t + 11);
    drain("drain_closed_read");

    // Row hit
    do_req(3'd3, 3'd2, 8'h55, 4'h1, 1'b0, 64'd0, t);
    push(RD, 3'd3, 3'd2, 8'h55, 4'h1, 64'd0, t + 2);
    drain("drain_hit");

    // Row conflict
    do_req(3'd3, 3'd2, 8'h0F, 4'h8, 1'b0, 64'd0, t);
    push(PRE, 3'd3, 3'd2, 8'h55, 4'h0, 64'd0, t + 2);
    push(ACT, 3'd3, 3'd2, 8'h0F, 4'h0, 64'd0, t + 8);
    push(RD,  3'd3, 3'd2, 8'h0F, 4'h8, 64'd0, t + 17);
    drain("drain_conflict");

    // Backpressure on ACT, then write
    cmd_ready = 1'b0;
    do_req(3'd1, 3'd1, 8'hFF, 4'h3, 1'b1, 64'hA5A5A5A5A5A5A5A5, t);
    push(ACT, 3'd1, 3'd1, 8'hFF, 4'h0, 64'd0, t + 6);
    push(WR,  3'd1, 3'd1, 8'hFF, 4'h3, 64'hA5A5A5A5A5A5A5A5, t + 15);
    repeat (5) @(posedge clk);
    #1 cmd_ready = 1'b1;
    drain("drain_backpressure");
    chk("act_held_cycles", 64'(last_act_run), 64'd5);

    // Bank independence
    do_req(3'd2, 3'd1, 8'hF0, 4'h0, 1'b0, 64'd0, t);
    push(ACT, 3'd2, 3'd1, 8'hF0, 4'h0, 64'd0, t + 2);
    push(RD,  3'd2, 3'd1, 8'hF0, 4'h0, 64'd0, t + 11);
    drain("drain_open_bg2b1");
    do_req(3'd3, 3'd2, 8'h0F, 4'h2, 1'b0, 64'd0, t);
    push(RD, 3'd3, 3'd2, 8'h0F, 4'h2, 64'd0, t + 2);
    drain("drain_hit_bg3b2");
    do_req(3'd2, 3'd1, 8'hF0, 4'h5, 1'b1, 64'h0123456789ABCDEF, t);
    push(WR, 3'd2, 3'd1, 8'hF0, 4'h5, 64'h0123456789ABCDEF, t + 2);
    drain("drain_hit_bg2b1");

    // Reset during WAIT_ACT
    do_req(3'd4, 3'd4, 8'h22, 4'h1, 1'b0, 64'd0, t);
    push(ACT, 3'd4, 3'd4, 8'h22, 4'h0, 64'd0, t + 2);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_req_ready", 64'(req_ready), 64'd1);
    chk("midreset_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("midreset_cmd", 64'(cmd_o), 64'(NOP));
    chk("midreset_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_rw_after_reset", 64'(exp_q.size()), 64'd0);

    // Table cleared: previously open banks need ACT again
    do_req(3'd4, 3'd4, 8'h22, 4'h1, 1'b0, 64'd0, t);
    push(ACT, 3'd4, 3'd4, 8'h22, 4'h0, 64'd0, t + 2);
    push(RD,  3'd4, 3'd4, 8'h22, 4'h1, 64'd0, t + 11);
    drain("drain_after_reset_a");
    do_req(3'd3, 3'd2, 8'h0F, 4'h2, 1'b0, 64'd0, t);
    push(ACT, 3'd3, 3'd2, 8'h0F, 4'h0, 64'd0, t + 2);
    push(RD,  3'd3, 3'd2, 8'h0F, 4'h2, 64'd0, t + 11);
    drain("drain_after_reset_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
